// File: rtl/uart_tx_fifo_if.sv
// ============================================================================
//  Module      : uart_tx_fifo_if
//  Description : Producer/consumer valid-ready byte stream for the TX FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_tx_fifo_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  // The FIFO itself sits on the slave side of both streams.
  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface : uart_tx_fifo_if

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : Synchronous byte FIFO feeding the UART transmitter, with
//                flush and occupancy status. Optional level/almost_full
//                outputs are enabled by defining UART_TX_FIFO_LEVEL_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
  parameter int DATA_WIDTH     = 8,
  parameter int DEPTH          = 16,
  parameter int ALMOST_FULL_TH = 12
) (
  input  wire logic                    clk,
  input  wire logic                    reset_n,
  input  wire logic                    ena,
  input  wire logic                    flush,
  uart_tx_fifo_if.slave                bus,
  output logic                         empty,
  output logic                         full
`ifdef UART_TX_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0]       level,
  output logic                         almost_full
`endif
);

  localparam int c_ADDR_W = $clog2(DEPTH);
  localparam int c_CNT_W  = c_ADDR_W + 1;

  localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_fifo: DEPTH must be a power of two and at least 2");
    end
    if (ALMOST_FULL_TH < 1 || ALMOST_FULL_TH > DEPTH) begin : g_bad_th
      $error("uart_tx_fifo: ALMOST_FULL_TH must lie in 1..DEPTH");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [c_ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_CNT_W-1:0]  count_q,  count_d;

  logic w_push;
  logic w_pop;

  // Status comes from the count so a wrapped full FIFO is never mistaken
  // for an empty one.
  assign empty = (count_q == '0);
  assign full  = (count_q == c_DEPTH);

  // in_ready is forced low during reset even though full is already clear.
  assign bus.in_ready  = ena & reset_n & ~full;
  assign bus.out_valid = ena & ~empty;
  assign bus.out_data  = mem_q[rd_ptr_q];

  assign w_push = bus.in_valid & bus.in_ready;
  assign w_pop  = bus.out_valid & bus.out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      // Flush wins over any handshake completing on the same edge.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; stale entries are unreachable once count is 0.
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      mem_q[wr_ptr_q] <= bus.in_data;
    end
  end

`ifdef UART_TX_FIFO_LEVEL_EN
  localparam logic [c_CNT_W-1:0] c_AF_TH = c_CNT_W'(ALMOST_FULL_TH);

  assign level       = count_q;
  assign almost_full = (count_q >= c_AF_TH);
`endif

endmodule : uart_tx_fifo

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ============================================================================
//  Module      : tb_uart_tx_fifo
//  Description : Directed self-checking bench for uart_tx_fifo (DEPTH=16).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic clk;
  logic reset_n;
  logic ena;
  logic flush;
  logic empty;
  logic full;
`ifdef UART_TX_FIFO_LEVEL_EN
  logic [4:0] level;
  logic       almost_full;
`endif

  int tests;
  int fails;

  uart_tx_fifo_if #(.DATA_WIDTH(DW)) bus ();

  uart_tx_fifo #(
    .DATA_WIDTH     (DW),
    .DEPTH          (DEPTH),
    .ALMOST_FULL_TH (12)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ena         (ena),
    .flush       (flush),
    .bus         (bus.slave),
    .empty       (empty),
    .full        (full)
`ifdef UART_TX_FIFO_LEVEL_EN
    ,
    .level       (level),
    .almost_full (almost_full)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset_n = 1'b0;
    ena = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || empty !== 1'b1 || full !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b empty=%b full=%b, need 0 0 1 0",
               bus.in_ready, bus.out_valid, empty, full);
    end
`ifdef UART_TX_FIFO_LEVEL_EN
    tests++;
    if (level !== 5'd0 || almost_full !== 1'b0) begin
      fails++;
      $display("FAIL reset_level: level=%0d almost_full=%b, need 0 0", level, almost_full);
    end
`endif
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, need 1 0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_fill_drain();
    bus.out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data = 8'(i);
    end
    @(negedge clk);
    bus.in_data = 8'hAA;
    #1;
    tests++;
    if (full !== 1'b1 || bus.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL fill_full: full=%b in_ready=%b, need 1 0", full, bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      #1;
      tests++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(i)) begin
        fails++;
        $display("FAIL drain_order[%0d]: valid=%b data=%h, need 1 %h", i, bus.out_valid, bus.out_data, 8'(i));
      end
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    #1;
    tests++;
    if (empty !== 1'b1 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL drain_empty: empty=%b out_valid=%b, need 1 0", empty, bus.out_valid);
    end
  endtask

  task automatic test_latency();
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data = 8'h55;
    #1;
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL latency_pre: out_valid=%b, need 0", bus.out_valid);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h55 || empty !== 1'b0) begin
      fails++;
      $display("FAIL latency_out: valid=%b data=%h empty=%b, need 1 55 0", bus.out_valid, bus.out_data, empty);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    #1;
    tests++;
    if (empty !== 1'b1 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL latency_pop: empty=%b out_valid=%b, need 1 0", empty, bus.out_valid);
    end
  endtask

  task automatic test_wrap();
    int pushed;
    int popped;
    pushed = 0;
    popped = 0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data = 8'(8'h30 + pushed);
      pushed++;
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data = 8'(8'h30 + pushed);
      bus.out_ready = 1'b1;
      pushed++;
      #1;
      tests++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1 || bus.out_data !== 8'(8'h30 + popped)) begin
        fails++;
        $display("FAIL wrap_stream[%0d]: valid=%b in_ready=%b data=%h, need 1 1 %h",
                 i, bus.out_valid, bus.in_ready, bus.out_data, 8'(8'h30 + popped));
      end
      popped++;
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      tests++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(8'h30 + popped)) begin
        fails++;
        $display("FAIL wrap_tail[%0d]: valid=%b data=%h, need 1 %h", i, bus.out_valid, bus.out_data, 8'(8'h30 + popped));
      end
      popped++;
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    #1;
    tests++;
    if (empty !== 1'b1) begin
      fails++;
      $display("FAIL wrap_count: empty=%b after 8 pops, need 1", empty);
    end
  endtask

  task automatic test_ena_stall();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data = 8'(8'hC0 + i);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ena = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data = 8'hEE;
      bus.out_ready = 1'b1;
      #1;
      tests++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || empty !== 1'b0) begin
        fails++;
        $display("FAIL ena_stall[%0d]: in_ready=%b out_valid=%b empty=%b, need 0 0 0",
                 i, bus.in_ready, bus.out_valid, empty);
      end
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ena = 1'b1;
      bus.in_valid = 1'b0;
      #1;
      tests++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(8'hC0 + i)) begin
        fails++;
        $display("FAIL ena_resume[%0d]: valid=%b data=%h, need 1 %h", i, bus.out_valid, bus.out_data, 8'(8'hC0 + i));
      end
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    #1;
    tests++;
    if (empty !== 1'b1) begin
      fails++;
      $display("FAIL ena_count: empty=%b after 5 pops, need 1", empty);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data = 8'(8'h10 + i);
    end
    @(negedge clk);
    flush = 1'b1;
    bus.in_data = 8'h77;
    #1;
    tests++;
    if (empty !== 1'b0 || bus.out_data !== 8'h10) begin
      fails++;
      $display("FAIL flush_pre: empty=%b head=%h, need 0 10", empty, bus.out_data);
    end
    @(negedge clk);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    tests++;
    if (empty !== 1'b1 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_empty: empty=%b out_valid=%b, need 1 0", empty, bus.out_valid);
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data = 8'h5A;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    tests++;
    if (bus.out_data !== 8'h5A || bus.out_valid !== 1'b1) begin
      fails++;
      $display("FAIL flush_head: valid=%b data=%h, need 1 5a", bus.out_valid, bus.out_data);
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    #1;
    tests++;
    if (empty !== 1'b1) begin
      fails++;
      $display("FAIL flush_nostore: empty=%b after one pop, need 1", empty);
    end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data = 8'(8'hA0 + i);
    end
    #2;
    reset_n = 1'b0;
    #1;
    tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || empty !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid: out_valid=%b in_ready=%b empty=%b, need 0 0 1", bus.out_valid, bus.in_ready, empty);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    tests++;
    if (empty !== 1'b1 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_after: empty=%b out_valid=%b in_ready=%b, need 1 0 1", empty, bus.out_valid, bus.in_ready);
    end
  endtask

`ifdef UART_TX_FIFO_LEVEL_EN
  task automatic test_level();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data = 8'(i);
      #1;
      tests++;
      if (level !== 5'(i) || almost_full !== 1'b0) begin
        fails++;
        $display("FAIL level_ramp[%0d]: level=%0d almost_full=%b, need %0d 0", i, level, almost_full, i);
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    tests++;
    if (level !== 5'd12 || almost_full !== 1'b1) begin
      fails++;
      $display("FAIL level_12: level=%0d almost_full=%b, need 12 1", level, almost_full);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    #1;
    tests++;
    if (level !== 5'd11 || almost_full !== 1'b0) begin
      fails++;
      $display("FAIL level_11: level=%0d almost_full=%b, need 11 0", level, almost_full);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    tests++;
    if (level !== 5'd0 || empty !== 1'b1) begin
      fails++;
      $display("FAIL level_flush: level=%0d empty=%b, need 0 1", level, empty);
    end
  endtask
`endif

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_fill_drain();
    test_latency();
    test_wrap();
    test_ena_stall();
    test_flush();
    test_reset_mid();
`ifdef UART_TX_FIFO_LEVEL_EN
    test_level();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_uart_tx_fifo

`default_nettype wire

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Synchronous byte FIFO that buffers the transmit stream directly upstream of the UART transmitter.
- Its output valid/ready pair connects straight to tx_data/tx_valid/tx_ready of the uart wrapper.
- Producers can burst bytes at clock rate while the transmitter drains them at the baud rate.
- Also provides a synchronous flush and occupancy status.

Parameters:
- DATA_WIDTH, 8, width of each FIFO entry; matches the UART data width.
- DEPTH, 16, number of entries; must be a power of two and at least 2.
- ALMOST_FULL_TH, 12, occupancy at or above which almost_full asserts; range 1..DEPTH.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- ena  input  1  block enable; when low, all handshakes stall and state holds.
- flush  input  1  synchronous clear of FIFO contents.
- in_data  input  DATA_WIDTH  byte from the producer.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  FIFO can accept a byte.
- out_data  output  DATA_WIDTH  head-of-FIFO byte; connects to uart tx_data.
- out_valid  output  1  FIFO non-empty; connects to uart tx_valid.
- out_ready  input  1  consumer accepts the head byte; connects to uart tx_ready.
- empty  output  1  occupancy == 0.
- full  output  1  occupancy == DEPTH.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low on reset_n; all state clears immediately on assertion.
- Reset values: pointers 0, count 0, empty=1, full=0, in_ready=0 while reset_n is low, out_valid=0. out_data is don't-care, but storage is not required to reset.
- After reset release: in_ready=1 provided ena=1.
- Pointers: write and read pointers are log2(DEPTH) bits, wrapping modulo DEPTH. count is log2(DEPTH)+1 bits and ranges 0..DEPTH.
- in_ready = ena & ~full. out_valid = ena & ~empty. out_data = mem[rd_ptr], driven combinationally from storage.
- Push: occurs when in_valid & in_ready at a clock edge. Writes mem[wr_ptr], increments wr_ptr.
- Pop: occurs when out_valid & out_ready at a clock edge. Increments rd_ptr.
- Push and pop together: both pointers advance and count is unchanged.
  - When full: in_ready=0, so only the pop occurs. No same-cycle pass-through.
  - When empty: out_valid=0, so only the push occurs.
- Latency: a byte pushed into an empty FIFO appears on out_valid/out_data the cycle after the push edge.
- Order: strict FIFO; no byte is duplicated or dropped under any legal handshake.
- Wrap-around: pointers roll from DEPTH-1 to 0 seamlessly. Full/empty are derived from count, not pointer equality.
- Holding: while out_valid=1 and out_ready=0, out_data stays stable.
- ena=0: no push or pop occurs; in_ready=0 and out_valid=0; pointers, count and contents are held. Resuming ena=1 restores the prior status.
- flush=1 at an edge: pointers and count go to 0 and any same-cycle push or pop is ignored. empty=1 from the next cycle. flush has priority over push/pop but not over reset.
- Reset mid-operation: in-flight contents are discarded. The downstream transmitter sees out_valid drop asynchronously.
- empty and full are not gated by ena.

Optional Feature:
- Macro: UART_TX_FIFO_LEVEL_EN.
- Defined: adds output port level (width log2(DEPTH)+1, equal to count) and output almost_full = (count >= ALMOST_FULL_TH).
  - Both reset to 0.
  - Both update in the same cycle as count.
- Undefined: neither port exists, no extra logic is generated, and all other behaviour is identical.

Test Plan:
- Fill to full, then drain: DEPTH=16, out_ready=0, push 0x00..0x0F.
  - in_ready=0 and full=1 after the 16th push.
  - A 17th push of 0xAA is not accepted.
  - Drain with out_ready=1: bytes come out as 0x00..0x0F in order, then empty=1.
- Single-byte latency: push 0x55 into an empty FIFO → out_valid=1 and out_data=0x55 on the next cycle. Pop → empty=1 on the following cycle.
- Simultaneous push/pop and wrap-around: hold count at 8 with continuous push/pop for 40 cycles using an incrementing byte pattern → count stays 8 and the output sequence is exactly the input sequence delayed by 8 entries.
- Stall with ena: at count=5, drive ena=0 for 10 cycles with in_valid=1 and out_ready=1 → in_ready=0, out_valid=0, count stays 5. With ena=1 the next popped byte is the original head.
- Flush and reset: at count=10, assert flush together with a push of 0x77 → empty=1 next cycle and 0x77 is not stored. Separately, assert reset_n=0 mid-burst → out_valid=0 immediately, and after release the FIFO is empty.
- With UART_TX_FIFO_LEVEL_EN defined and ALMOST_FULL_TH=12: push 12 bytes → level=12 and almost_full=1. Pop one → level=11 and almost_full=0.
